reset_sched: RTL and testbench

- Arbitrates and sequences system-reset requests from several sources into a single `reset_req` pulse for the system controller.
- Sources: ESP32 command, keyboard three-finger reset, software register write, and an optional watchdog.
- Records which source caused the reset.
- Confirms the reset completed by watching the internal system reset.
- Enforces a hold-off window so request storms cannot retrigger back-to-back resets.
- Clocked on `sysclk`. Its own `reset_n` is power-on only, so the block survives the system resets it causes.

---
 rtl/sysctrl_pkg.sv | 30 +++
 rtl/reset_sched_wdt.sv | 33 +++
 rtl/reset_sched.sv | 181 ++++++++++++++++++
 tb/tb_reset_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysctrl_pkg.sv
// Shared definitions for the system-controller reset scheduler:
// FSM state encoding, request source slots and default timing constants.
package sysctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    // Request source slots in req / req_mask / cause
    localparam int SRC_ESP = 0;
    localparam int SRC_KBD = 1;
    localparam int SRC_WDT = 2;
    localparam int SRC_SW  = 3;

    localparam int NREQ_DEF        = 4;
    localparam int PULSE_LEN_DEF   = 4;
    localparam int ACK_TIMEOUT_DEF = 1024;
    localparam int HOLDOFF_CYC_DEF = 256;
    localparam int WDT_W_DEF       = 24;

    // Counter width for a count up to max_val: one spare bit above log2
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/reset_sched_wdt.sv
// Watchdog counter for the reset scheduler. Raises wdt_fire for one cycle
// when the counter reaches all-ones, then restarts from zero. Instantiated
// by reset_sched only when RESET_SCHED_WATCHDOG_EN is defined.
module reset_sched_wdt #(
    parameter int WDT_W = 24
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic wdt_en,
    input  logic wdt_kick,
    input  logic busy,
    output logic wdt_fire
);

    logic [WDT_W-1:0] cnt;

    // Fire on terminal count; suppressed whenever the counter is being cleared
    assign wdt_fire = wdt_en & ~wdt_kick & ~busy & (&cnt);

    // Count while enabled and idle; clear on disable, kick, busy or terminal count
    always_ff @(posedge sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (!reset_n) begin
            cnt <= '0;
        end else if (!wdt_en || wdt_kick || busy || (&cnt)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reset_sched.sv
// Reset scheduler: turns rising edges on several reset-request sources into
// a single fixed-length reset_req pulse, records the cause, confirms the
// system reset went high then low (or flags a timeout) and then ignores new
// requests for a hold-off window.
// Optional watchdog source on slot 2: define RESET_SCHED_WATCHDOG_EN.
module reset_sched
    import sysctrl_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int PULSE_LEN   = PULSE_LEN_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
    parameter int WDT_W       = WDT_W_DEF
) (
    input  logic            sysclk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_mask,
    input  logic            sys_reset,
    input  logic            cause_clr,
    input  logic            wdt_en,
    input  logic            wdt_kick,
    output logic            reset_req,
    output logic            busy,
    output logic [NREQ-1:0] cause,
    output logic            cause_valid,
    output logic            ack_err
);

    localparam int PCW = cnt_w(PULSE_LEN);
    localparam int TCW = cnt_w(ACK_TIMEOUT);
    localparam int HCW = cnt_w(HOLDOFF_CYC);

    localparam logic [PCW-1:0] PULSE_LAST   = PCW'(PULSE_LEN - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(ACK_TIMEOUT - 1);
    localparam logic [HCW-1:0] HOLDOFF_LAST = HCW'(HOLDOFF_CYC - 1);

    state_t          state;
    logic [NREQ-1:0] req_eff;
    logic [NREQ-1:0] req_q;
    logic [NREQ-1:0] wdt_vec;
    logic [NREQ-1:0] edge_v;
    logic [NREQ-1:0] pending;
    logic            armed;
    logic [PCW-1:0]  pcnt;
    logic [TCW-1:0]  tcnt;
    logic [HCW-1:0]  hcnt;
    logic            ack_timeout;

    assign busy = (state != IDLE);

`ifdef RESET_SCHED_WATCHDOG_EN
    logic wdt_fire;
    logic unused_req_wdt;

    reset_sched_wdt #(
        .WDT_W (WDT_W)
    ) u_wdt (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .wdt_en   (wdt_en),
        .wdt_kick (wdt_kick),
        .busy     (busy),
        .wdt_fire (wdt_fire)
    );

    // The watchdog owns slot 2: the external level there is ignored
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        req_eff          = req;
        req_eff[SRC_WDT] = 1'b0;
        wdt_vec          = '0;
        wdt_vec[SRC_WDT] = wdt_fire;
    end

    assign unused_req_wdt = req[SRC_WDT];
`else
    localparam int unused_wdt_w = WDT_W;
    logic unused_wdt;

    // Without the watchdog every slot is an ordinary external request
    always_comb begin
        req_eff = req;
        wdt_vec = '0;
    end

    assign unused_wdt = wdt_en ^ wdt_kick;
`endif

    // Rising-edge detect; gated off for the first cycle after reset so a
    // level held through reset does not count as a new request
    always_comb begin
        edge_v = '0;
        if (armed) begin
            edge_v = ((req_eff & ~req_q) | wdt_vec) & ~req_mask;
        end
    end

    // Shared WAIT_HI/WAIT_LO timeout counter has reached its terminal count
    assign ack_timeout = (tcnt >= TIMEOUT_LAST);

    // Sequencer FSM with registered outputs, edge history and counters
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_q       <= '0;
            armed       <= 1'b0;
            pending     <= '0;
            reset_req   <= 1'b0;
            cause       <= '0;
            cause_valid <= 1'b0;
            ack_err     <= 1'b0;
            pcnt        <= '0;
            tcnt        <= '0;
            hcnt        <= '0;
        end else begin
            armed   <= 1'b1;
            req_q   <= req_eff;
            pending <= '0;

            // A capture later in this block overrides the clear
            if (cause_clr) begin
                cause       <= '0;
                cause_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (|pending) begin
                        cause       <= pending;
                        cause_valid <= 1'b1;
                        ack_err     <= 1'b0;
                        reset_req   <= 1'b1;
                        pcnt        <= '0;
                        state       <= PULSE;
                    end else begin
                        pending <= pending | edge_v;
                    end
                end

                PULSE: begin
                    if (pcnt == PULSE_LAST) begin
                        reset_req <= 1'b0;
                        tcnt      <= '0;
                        state     <= WAIT_HI;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end

                WAIT_HI, WAIT_LO: begin
                    if (!ack_timeout) begin
                        tcnt <= tcnt + 1'b1;
                    end
                    if (state == WAIT_HI && sys_reset) begin
                        state <= WAIT_LO;
                    end else if (state == WAIT_LO && !sys_reset) begin
                        hcnt  <= '0;
                        state <= HOLDOFF;
                    end else if (ack_timeout) begin
                        ack_err <= 1'b1;
                        hcnt    <= '0;
                        state   <= HOLDOFF;
                    end
                end

                HOLDOFF: begin
                    if (hcnt == HOLDOFF_LAST) begin
                        state <= IDLE;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sched.sv
// Directed self-checking bench for reset_sched with default timing
// (PULSE_LEN 4, ACK_TIMEOUT 1024, HOLDOFF_CYC 256) and WDT_W 4.
// Cycle numbers are counted from the first clock edge after reset release;
// inputs set at cycle c are seen by the edge that ends cycle c.
module tb_reset_sched;

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] req_mask;
    logic       sys_reset;
    logic       cause_clr;
    logic       wdt_en;
    logic       wdt_kick;
    logic       reset_req;
    logic       busy;
    logic [3:0] cause;
    logic       cause_valid;
    logic       ack_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    logic prev_rr = 1'b0;

    reset_sched #(
        .NREQ        (4),
        .PULSE_LEN   (4),
        .ACK_TIMEOUT (1024),
        .HOLDOFF_CYC (256),
        .WDT_W       (4)
    ) dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .req         (req),
        .req_mask    (req_mask),
        .sys_reset   (sys_reset),
        .cause_clr   (cause_clr),
        .wdt_en      (wdt_en),
        .wdt_kick    (wdt_kick),
        .reset_req   (reset_req),
        .busy        (busy),
        .cause       (cause),
        .cause_valid (cause_valid),
        .ack_err     (ack_err)
    );

    always #5 sysclk = ~sysclk;

    // Count rising edges of reset_req to catch extra or missing pulses
    always @(posedge sysclk) begin
        prev_rr <= reset_req;
        if (reset_req && !prev_rr) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        reset_n   = 1'b0;
        req       = 4'b0000;
        req_mask  = 4'b0000;
        sys_reset = 1'b0;
        cause_clr = 1'b0;
        wdt_en    = 1'b0;
        wdt_kick  = 1'b0;
        tick(); tick(); tick();

        // Reset values
        check("rst_reset_req",   reset_req,   0);
        check("rst_busy",        busy,        0);
        check("rst_cause",       cause,       0);
        check("rst_cause_valid", cause_valid, 0);
        check("rst_ack_err",     ack_err,     0);

        reset_n = 1'b1;
        cyc = 0;

        // Pulse-and-ack: edge at 10, pulse 12..15, WAIT_HI 16, WAIT_LO 21,
        // HOLDOFF 42..297, IDLE 298
        at(10); req[1] = 1'b1;
        at(11); check("t1_no_pulse_yet", reset_req, 0);
                check("t1_idle_pending", busy, 0);
        at(12); check("t1_pulse_rise",  reset_req,   1);
                check("t1_cause",       cause,       4'b0010);
                check("t1_cause_valid", cause_valid, 1);
                check("t1_busy",        busy,        1);
        at(15); check("t1_pulse_last",  reset_req,   1);
        at(16); check("t1_pulse_fall",  reset_req,   0);
                check("t1_busy_wait",   busy,        1);
        at(20); sys_reset = 1'b1;
        at(41); sys_reset = 1'b0;
        at(200); check("t1_ack_err",    ack_err,     0);
        at(296); check("t1_holdoff_busy", busy,      1);
        at(298); check("t1_idle",       busy,        0);
                 check("t1_pulses",     pulses,      1);

        // Simultaneous sources: req[0] and req[3] rise together at 300
        at(300); req = 4'b1011;
        at(302); check("t2_pulse",      reset_req,   1);
                 check("t2_cause",      cause,       4'b1001);
        at(310); sys_reset = 1'b1;
        at(315); sys_reset = 1'b0;
        // HOLDOFF 316..571: a fresh req[1] edge here is discarded
        at(320); req[1] = 1'b0;
        at(330); req[1] = 1'b1;
        at(332); check("t2_holdoff_no_pulse", reset_req, 0);
                 check("t2_holdoff_cause",    cause,     4'b1001);
        at(580); check("t2_idle",       busy,        0);
                 check("t2_cause_kept", cause,       4'b1001);
                 check("t2_pulses",     pulses,      2);

        // Masking: toggles on masked req[0] never trigger
        at(600); req_mask = 4'b0001; req[0] = 1'b0;
        at(602); req[0] = 1'b1;
        at(604); req[0] = 1'b0;
        at(606); req[0] = 1'b1;
        at(610); check("t3_masked_busy", busy,       0);
                 check("t3_masked_pulses", pulses,   2);

        // Held level across reset: req[1] stays high through reset_n
        at(620); reset_n = 1'b0;
        at(623); check("t3_rst_cause",  cause,       0);
                 check("t3_rst_valid",  cause_valid, 0);
                 reset_n = 1'b1;
        at(630); check("t3_held_no_pulse", busy,     0);
                 check("t3_held_pulses", pulses,     2);
        // Re-rise req[1]: edge 633, pulse from 635; sys_reset stays 0
        at(631); req[1] = 1'b0;
        at(633); req[1] = 1'b1;
        at(635); check("t3_rerise_pulse", reset_req, 1);
                 check("t3_rerise_cause", cause,     4'b0010);

        // Timeout: WAIT_HI 639..1662, ack_err and HOLDOFF at 1663, IDLE 1919
        at(1662); check("t4_pre_timeout", ack_err,   0);
                  check("t4_busy_wait",   busy,      1);
        at(1663); check("t4_ack_err",     ack_err,   1);
        at(1918); check("t4_holdoff_end", busy,      1);
        at(1919); check("t4_idle",        busy,      0);
                  check("t4_ack_err_sticky", ack_err, 1);

        // cause_clr collides with capture at 1923
        at(1920); req_mask = 4'b0000; req[3] = 1'b0;
        at(1922); req[3] = 1'b1;
        at(1923); cause_clr = 1'b1;
        at(1924); cause_clr = 1'b0;
                  check("t5_capture_wins", cause,       4'b1000);
                  check("t5_valid",        cause_valid, 1);
                  check("t5_ack_err_clr",  ack_err,     0);
        at(1930); sys_reset = 1'b1;
        at(1935); sys_reset = 1'b0;
        // Lone strobe during HOLDOFF (1936..2191)
        at(2000); cause_clr = 1'b1;
        at(2001); cause_clr = 1'b0;
                  check("t5_clr_cause", cause,       0);
                  check("t5_clr_valid", cause_valid, 0);
                  check("t5_clr_busy",  busy,        1);
        at(2192); check("t5_idle",      busy,        0);

        // Mid-sequence reset_n aborts the pulse
        at(2195); req[0] = 1'b0;
        at(2200); req[0] = 1'b1;
        at(2202); check("t6_pulse",       reset_req, 1);
        at(2203); reset_n = 1'b0;
        at(2204); check("t6_abort_req",   reset_req, 0);
                  check("t6_abort_busy",  busy,      0);
                  check("t6_abort_cause", cause,     0);
                  reset_n = 1'b1;
        at(2215); check("t6_no_repulse",  busy,      0);
                  check("t6_pulses",      pulses,    5);

`ifdef RESET_SCHED_WATCHDOG_EN
        // Watchdog: counts 0 at 2220 to 15 at 2235, capture at 2237
        at(2220); wdt_en = 1'b1;
        at(2236); check("w1_not_yet",   reset_req, 0);
        at(2237); check("w1_pulse",     reset_req, 1);
                  check("w1_cause",     cause,     4'b0100);
        at(2245); sys_reset = 1'b1;
        at(2250); sys_reset = 1'b0;
        at(2260); wdt_en = 1'b0;
        at(2506); check("w1_holdoff",   busy,      1);
        at(2507); check("w1_idle",      busy,      0);

        // Kick every 10 cycles keeps the watchdog quiet
        at(2510); wdt_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            at(2515 + 10 * k); wdt_kick = 1'b1;
            tick();            wdt_kick = 1'b0;
        end
        at(2614); check("w2_kick_busy",   busy,   0);
                  check("w2_kick_pulses", pulses, 6);

        // Masked watchdog slot never triggers
        req_mask = 4'b0100;
        at(2660); check("w3_mask_busy",   busy,   0);
                  check("w3_mask_pulses", pulses, 6);
        wdt_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
